// File: rtl/bit_upsample_gen_pkg.sv
// Shared definitions for the bit upsampler in front of the Gaussian TX filter.
package bit_upsample_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_TAIL = 2'd2
  } ups_state_t;

  localparam int DEF_SAMPLE_PER_SYMBOL = 8;
  localparam int GAUSS_NUM_TAP         = 17;
  // Tail length drains the filter delay line: one sample per tap beyond the first.
  localparam int DEF_TAIL_SAMPLES      = GAUSS_NUM_TAP - 1;

endpackage

// File: rtl/bit_upsample_gen.sv
// Repeats each accepted info bit SAMPLE_PER_SYMBOL times toward the Gaussian filter.
// Define BIT_UPSAMPLE_TAIL_EN to append TAIL_SAMPLES copies of the final bit.
module bit_upsample_gen
  import bit_upsample_gen_pkg::*;
#(
  parameter int SAMPLE_PER_SYMBOL = DEF_SAMPLE_PER_SYMBOL,
  parameter int TAIL_SAMPLES      = DEF_TAIL_SAMPLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       info_bit,
  input  logic       info_bit_valid,
  input  logic       info_bit_valid_last,
  output logic       info_bit_ready,
  output logic       bit_upsample,
  output logic       bit_upsample_valid,
  output logic       bit_upsample_valid_last,
  output logic       underrun,
  output ups_state_t dbg_state
);

  // Handshake: a bit transfers on any rising edge where info_bit_valid and
  // info_bit_ready are both high; ready depends only on internal state.
  localparam int CNT_W = $clog2(SAMPLE_PER_SYMBOL);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(SAMPLE_PER_SYMBOL - 1);

  ups_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             hbit, hbit_nxt;
  logic             hlast, hlast_nxt;
  logic             stall, stall_nxt;
  logic             out_bit_nxt, valid_nxt, vlast_nxt, under_nxt;
  logic             cnt_end;

`ifdef BIT_UPSAMPLE_TAIL_EN
  localparam logic [7:0] TAIL_END = 8'(TAIL_SAMPLES - 1);
  logic [7:0] tail_cnt, tail_cnt_nxt;
`else
  logic unused_tail_samples;
  assign unused_tail_samples = ^8'(TAIL_SAMPLES);
`endif

  assign cnt_end        = (cnt == CNT_END);
  assign info_bit_ready = rst_n && ((state == ST_IDLE) ||
                                    ((state == ST_RUN) && cnt_end && !hlast));
  assign dbg_state      = state;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    hbit_nxt    = hbit;
    hlast_nxt   = hlast;
    stall_nxt   = stall;
    out_bit_nxt = bit_upsample;
    valid_nxt   = 1'b0;
    vlast_nxt   = 1'b0;
    under_nxt   = 1'b0;
`ifdef BIT_UPSAMPLE_TAIL_EN
    tail_cnt_nxt = tail_cnt;
`endif
    case (state)
      ST_IDLE: begin
        if (info_bit_valid) begin
          state_nxt   = ST_RUN;
          cnt_nxt     = '0;
          hbit_nxt    = info_bit;
          hlast_nxt   = info_bit_valid_last;
          stall_nxt   = 1'b0;
          out_bit_nxt = info_bit;
          valid_nxt   = 1'b1;
        end
      end
      ST_RUN: begin
        if (!cnt_end) begin
          cnt_nxt     = cnt + 1'b1;
          out_bit_nxt = hbit;
          valid_nxt   = 1'b1;
`ifndef BIT_UPSAMPLE_TAIL_EN
          vlast_nxt   = hlast && (cnt_nxt == CNT_END);
`endif
        end else if (!hlast) begin
          if (info_bit_valid) begin
            cnt_nxt     = '0;
            hbit_nxt    = info_bit;
            hlast_nxt   = info_bit_valid_last;
            stall_nxt   = 1'b0;
            out_bit_nxt = info_bit;
            valid_nxt   = 1'b1;
          end else begin
            // Starved mid-packet: hold the counter and flag only the first bubble.
            stall_nxt = 1'b1;
            under_nxt = !stall;
          end
        end else begin
`ifdef BIT_UPSAMPLE_TAIL_EN
          state_nxt    = ST_TAIL;
          tail_cnt_nxt = '0;
          out_bit_nxt  = hbit;
          valid_nxt    = 1'b1;
          vlast_nxt    = (TAIL_END == 8'd0);
`else
          state_nxt = ST_IDLE;
`endif
        end
      end
`ifdef BIT_UPSAMPLE_TAIL_EN
      ST_TAIL: begin
        if (tail_cnt == TAIL_END) begin
          state_nxt = ST_IDLE;
        end else begin
          tail_cnt_nxt = tail_cnt + 8'd1;
          out_bit_nxt  = hbit;
          valid_nxt    = 1'b1;
          vlast_nxt    = (tail_cnt_nxt == TAIL_END);
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                   <= ST_IDLE;
      cnt                     <= '0;
      hbit                    <= 1'b0;
      hlast                   <= 1'b0;
      stall                   <= 1'b0;
      bit_upsample            <= 1'b0;
      bit_upsample_valid      <= 1'b0;
      bit_upsample_valid_last <= 1'b0;
      underrun                <= 1'b0;
`ifdef BIT_UPSAMPLE_TAIL_EN
      tail_cnt                <= '0;
`endif
    end else begin
      state                   <= state_nxt;
      cnt                     <= cnt_nxt;
      hbit                    <= hbit_nxt;
      hlast                   <= hlast_nxt;
      stall                   <= stall_nxt;
      bit_upsample            <= out_bit_nxt;
      bit_upsample_valid      <= valid_nxt;
      bit_upsample_valid_last <= vlast_nxt;
      underrun                <= under_nxt;
`ifdef BIT_UPSAMPLE_TAIL_EN
      tail_cnt                <= tail_cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_bit_upsample_gen.sv
// Directed bench for bit_upsample_gen: packets, starvation gap, single bit, mid-packet reset.
module tb_bit_upsample_gen;
  import bit_upsample_gen_pkg::*;

  localparam int SPS  = 8;
  localparam int TAIL = 16;
`ifdef BIT_UPSAMPLE_TAIL_EN
  localparam int TAIL_ADD = TAIL;
`else
  localparam int TAIL_ADD = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic       info_bit;
  logic       info_bit_valid;
  logic       info_bit_valid_last;
  logic       info_bit_ready;
  logic       bit_upsample;
  logic       bit_upsample_valid;
  logic       bit_upsample_valid_last;
  logic       underrun;
  ups_state_t dbg_state;

  int total = 0;
  int bad   = 0;

  // monitor-owned records
  logic [1:0] got_q[$];
  int         ur_cnt     = 0;
  int         bubble_cnt = 0;
  int         last_cnt   = 0;
  int         last_pos   = 0;
  int         tail_rdy   = 0;
  int         tail_from  = 1 << 30;
  logic       in_pkt     = 1'b0;

  logic [1:0] exp_q[$];

  bit_upsample_gen #(
    .SAMPLE_PER_SYMBOL(SPS),
    .TAIL_SAMPLES     (TAIL)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .info_bit               (info_bit),
    .info_bit_valid         (info_bit_valid),
    .info_bit_valid_last    (info_bit_valid_last),
    .info_bit_ready         (info_bit_ready),
    .bit_upsample           (bit_upsample),
    .bit_upsample_valid     (bit_upsample_valid),
    .bit_upsample_valid_last(bit_upsample_valid_last),
    .underrun               (underrun),
    .dbg_state              (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      in_pkt = 1'b0;
    end else begin
      if (bit_upsample_valid) begin
        got_q.push_back({bit_upsample, bit_upsample_valid_last});
        in_pkt = 1'b1;
        if (info_bit_ready && got_q.size() > tail_from) tail_rdy++;
        if (bit_upsample_valid_last) begin
          last_cnt++;
          last_pos = got_q.size();
          in_pkt   = 1'b0;
        end
      end else if (in_pkt) begin
        bubble_cnt++;
      end
      if (underrun) ur_cnt++;
    end
  end

  // driver: optional starvation gap of 'gap' cycles once the DUT asks for the bit
  task automatic send_bit(input logic b, input logic l, input int gap);
    int n;
    n = 0;
    @(negedge clk);
    if (gap > 0) begin
      info_bit_valid = 1'b0;
      while (!info_bit_ready && n < 500) begin
        @(negedge clk);
        n++;
      end
      repeat (gap) @(negedge clk);
    end
    info_bit            = b;
    info_bit_valid      = 1'b1;
    info_bit_valid_last = l;
    while (!info_bit_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("hs_timeout", 32'd0, 32'd1);
    @(posedge clk);
  endtask

  task automatic run_pkt(input string tag, input logic [15:0] bits, input int nb,
                         input int gap_at, input int gap_len);
    int base, ur0, bub0, last0, rdy0, n, lim;
    base  = got_q.size();
    ur0   = ur_cnt;
    bub0  = bubble_cnt;
    last0 = last_cnt;
    rdy0  = tail_rdy;
    tail_from = base + nb * SPS;
    exp_q.delete();
    for (int i = 0; i < nb; i++)
      for (int k = 0; k < SPS; k++) exp_q.push_back({bits[i], 1'b0});
    for (int k = 0; k < TAIL_ADD; k++) exp_q.push_back({bits[nb-1], 1'b0});
    exp_q[exp_q.size()-1][0] = 1'b1;

    for (int i = 0; i < nb; i++) begin
      send_bit(bits[i], (i == nb - 1), (i == gap_at) ? gap_len : 0);
      if (i == 0) begin
        #1;
        check({tag, "_latency"}, 32'(bit_upsample_valid), 32'd1);
      end
    end
    @(negedge clk);
    info_bit_valid      = 1'b0;
    info_bit_valid_last = 1'b0;
    n = 0;
    while (last_cnt == last0 && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 2000) check({tag, "_last_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    #1;
    check({tag, "_idle_valid"}, 32'(bit_upsample_valid), 32'd0);
    check({tag, "_idle_ready"}, 32'(info_bit_ready), 32'd1);

    check({tag, "_count"}, 32'(got_q.size() - base), 32'(exp_q.size()));
    lim = got_q.size() - base;
    if (lim > exp_q.size()) lim = exp_q.size();
    for (int k = 0; k < lim; k++)
      check({tag, "_sample"}, 32'(got_q[base+k]), 32'(exp_q[k]));
    check({tag, "_last_pos"}, 32'(last_pos - base), 32'(exp_q.size()));
    check({tag, "_last_cnt"}, 32'(last_cnt - last0), 32'd1);
    check({tag, "_bubbles"}, 32'(bubble_cnt - bub0), 32'(gap_len));
    check({tag, "_underrun"}, 32'(ur_cnt - ur0), (gap_len > 0) ? 32'd1 : 32'd0);
    check({tag, "_tail_ready"}, 32'(tail_rdy - rdy0), 32'd0);
  endtask

  initial begin
    int last0;
    rst_n               = 1'b0;
    info_bit            = 1'b0;
    info_bit_valid      = 1'b0;
    info_bit_valid_last = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_bit", 32'(bit_upsample), 32'd0);
    check("rst_valid", 32'(bit_upsample_valid), 32'd0);
    check("rst_last", 32'(bit_upsample_valid_last), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_ready", 32'(info_bit_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_ready", 32'(info_bit_ready), 32'd1);
    check("rel_valid", 32'(bit_upsample_valid), 32'd0);

    run_pkt("p101", 16'b101, 3, -1, 0);
    run_pkt("gap3", 16'b101, 3, 1, 3);
    run_pkt("single0", 16'b0, 1, -1, 0);
    run_pkt("p0110", 16'b0110, 4, -1, 0);
    run_pkt("gap1", 16'b1010, 4, 2, 1);

    // reset during sample 5 of bit 2
    last0 = last_cnt;
    send_bit(1'b1, 1'b0, 0);
    send_bit(1'b0, 1'b0, 0);
    repeat (5) @(negedge clk);
    info_bit_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bit_upsample_valid), 32'd0);
    check("mid_rst_bit", 32'(bit_upsample), 32'd0);
    check("mid_rst_last", 32'(bit_upsample_valid_last), 32'd0);
    check("mid_rst_ready", 32'(info_bit_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_nolast", 32'(last_cnt - last0), 32'd0);
    run_pkt("after_rst", 16'b01, 2, -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit_upsample_gen.md
# bit_upsample_gen

Upstream neighbour of the Gaussian filter in the BLE TX chain. Accepts one information bit per handshake from the packet/whitening stage, repeats each bit SAMPLE_PER_SYMBOL times, and drives the filter's `bit_upsample` / `bit_upsample_valid` / `bit_upsample_valid_last` inputs. Optionally appends a tail of repeated final-bit samples so the filter delay line drains the last symbol fully.

## Interface
- SAMPLE_PER_SYMBOL, 8, output samples per input bit; legal range 2..64.
- TAIL_SAMPLES, 16, tail samples appended after the last bit (matches filter taps − 1); used only with tail feature; legal range 1..255.
- clk  input  1  single clock.
- rst_n  input  1  reset, asynchronous and active-low.
- info_bit  input  1  bit to upsample.
- info_bit_valid  input  1  upstream holds info_bit valid.
- info_bit_valid_last  input  1  qualifies info_bit as last bit of packet; sampled only on handshake.
- info_bit_ready  output  1  block accepts info_bit this cycle.
- bit_upsample  output  1  repeated bit to filter.
- bit_upsample_valid  output  1  sample strobe.
- bit_upsample_valid_last  output  1  final sample of packet.
- underrun  output  1  one-cycle pulse: mid-packet bubble caused by upstream starvation.

## Operation
- Handshake on info_bit_valid && info_bit_ready; bit and last flag latched into holding regs.
- FSM states: IDLE, RUN, TAIL (TAIL exists only with tail feature).
- IDLE: ready=1. Handshake → RUN, sample counter=0, latch bit/last.
- RUN: emit held bit, valid=1, counter increments 0..SPS-1.
  - ready=1 only when counter==SPS-1 and held bit not last; handshake then reloads the bit, counter→0, giving gap-free output.
  - counter==SPS-1, not last, no handshake: enter stall sub-condition — valid=0, counter stays SPS-1, ready stays 1; underrun pulses once on first stall cycle only; resume on next handshake.
  - counter==SPS-1 and held bit last: tail feature on → TAIL, tail counter=0; off → IDLE, valid_last=1 on this sample.
- TAIL: emit held (last) bit, valid=1, ready=0, for TAIL_SAMPLES cycles; valid_last=1 on the final one; then IDLE.
- bit_upsample holds its last value when valid=0.
- info_bit_valid_last on a single-bit packet: legal; packet = SPS samples (+tail).
- Counter width $clog2(SAMPLE_PER_SYMBOL); tail counter 8 bits.

## Timing
- All outputs registered. Reset: bit_upsample=0, bit_upsample_valid=0, bit_upsample_valid_last=0, underrun=0, info_bit_ready=0 asserted combinationally from state (IDLE after reset → 1 once rst_n deasserts).
- Latency: handshake at edge t → first sample valid in cycle t+1.
- Continuous upstream: exactly SPS valid cycles per bit, no bubbles.
- Packet of N bits: N·SPS valid samples (+TAIL_SAMPLES), valid_last on last only.
- Next packet handshake earliest the cycle after valid_last (IDLE).
- rst_n asserted mid-packet: immediate return to IDLE, all outputs 0, partial packet discarded, no valid_last.

## Configuration
- BIT_UPSAMPLE_TAIL_EN defined: TAIL state and tail counter present; valid_last on final tail sample.
- Undefined: no TAIL; valid_last on SPS-th repeat of last bit; TAIL_SAMPLES ignored.

## Structure
- Shared package: FSM state enum (IDLE/RUN/TAIL), default SPS and tail constants shared with gauss filter NUM_TAP.
- Single module; no sub-module needed (counters and FSM are small).

## Test plan
- Reset: rst_n low → all outputs 0; release → ready=1, valid=0.
- SPS=8, bits 1,0,1 (last) continuous, tail off → 24 valid samples 8×1,8×0,8×1, no bubbles, valid_last only on sample 24.
- Same with BIT_UPSAMPLE_TAIL_EN, TAIL_SAMPLES=16 → 40 valid samples, last 16 are 1, valid_last on sample 40, ready=0 throughout tail.
- Upstream gap of 3 cycles after bit 1 → valid low 3 cycles, underrun one pulse, counter resumes, total still 24 samples.
- Single-bit packet bit=0 last → 8 samples of 0, valid_last on 8th, IDLE next cycle.
- rst_n asserted at sample 5 of bit 2 → outputs 0 immediately, new packet after release starts cleanly at counter 0.
